fetch_sequencer: RTL and testbench

- IF-stage controller for the 5-stage MIPS pipeline.
- Owns the PC register and sequences instruction-memory requests.
- Accepts branch/jump redirects from the next-PC calculator in ID, honouring the one-instruction delay slot.
- Holds the IF/ID payload under hazard-unit stall and reports its own busy state back to the hazard unit.

---
 rtl/mips_pkg.sv | 14 +
 rtl/fetch_skid_buf.sv | 36 +++
 rtl/fetch_sequencer.sv | 141 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: fetch defaults, NOP encoding and IF-stage FSM states.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
    localparam logic [31:0] NOP            = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StFetch = 2'd1,
        StHold  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register for a fetch that completes while ID is stalled.
module fetch_skid_buf (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc
);

    logic        r_valid;
    logic [31:0] r_instr;
    logic [31:0] r_pc;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_valid <= 1'b0;
            r_instr <= 32'd0;
            r_pc    <= 32'd0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// IF-stage controller: owns the PC, sequences imem requests, honours delay-slot redirects.
// Optional misaligned-fetch exception enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
`endif
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_npc,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic        o_if_valid,
    output logic [31:0] o_if_instr,
    output logic [31:0] o_if_pc,
    output logic [31:0] o_if_pc4,
    output logic        o_fetch_busy,
    output logic        o_fetch_exc
);

    fetch_state_e r_state, w_state_d;
    logic [31:0]  r_pc, r_pend_npc;
    logic         r_pend_v;
    logic         r_if_valid;
    logic [31:0]  r_if_instr, r_if_pc, r_if_pc4;

    logic         w_misalign, w_in_fetch, w_redirect;
    logic         w_deliver_mem, w_deliver_skid, w_complete, w_capture, w_bubble;
    logic         w_skid_valid;
    logic [31:0]  w_skid_instr, w_skid_pc, w_next_pc, w_done_pc;

`ifdef FETCH_ALIGN_CHECK_EN
    logic         r_fetch_exc;
    assign w_misalign = (r_state == StFetch) && (r_pc[1:0] != 2'b00);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_in_fetch     = (r_state == StFetch) && !w_misalign;
    assign w_redirect     = i_redirect_valid && !i_stall;
    assign w_deliver_mem  = w_in_fetch && i_imem_ack && !i_stall;
    assign w_capture      = w_in_fetch && i_imem_ack && i_stall;
    assign w_bubble       = w_in_fetch && !i_imem_ack && !i_stall;
    assign w_deliver_skid = (r_state == StHold) && w_skid_valid && !i_stall;
    assign w_complete     = w_deliver_mem || w_deliver_skid;
    assign w_done_pc      = w_deliver_skid ? w_skid_pc : r_pc;

    // A redirect seen this cycle outranks an older pending one: latest target wins.
    assign w_next_pc = w_redirect ? i_redirect_npc :
                       r_pend_v   ? r_pend_npc     : r_pc + 32'd4;

    fetch_skid_buf u_skid (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_capture),
        .i_clear (w_deliver_skid),
        .i_instr (i_imem_rdata),
        .i_pc    (r_pc),
        .o_valid (w_skid_valid),
        .o_instr (w_skid_instr),
        .o_pc    (w_skid_pc)
    );

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  w_state_d = StFetch;
            StFetch: if (w_capture) w_state_d = StHold;
            StHold:  if (!i_stall) w_state_d = StFetch;
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= StIdle;
            r_pc       <= RESET_PC;
            r_pend_v   <= 1'b0;
            r_pend_npc <= 32'd0;
            r_if_valid <= 1'b0;
            r_if_instr <= NOP;
            r_if_pc    <= 32'd0;
            r_if_pc4   <= 32'd0;
`ifdef FETCH_ALIGN_CHECK_EN
            r_fetch_exc <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            if (w_complete) begin
                r_if_valid <= 1'b1;
                r_if_instr <= w_deliver_skid ? w_skid_instr : i_imem_rdata;
                r_if_pc    <= w_done_pc;
                r_if_pc4   <= w_done_pc + 32'd4;
                r_pc       <= w_next_pc;
                r_pend_v   <= 1'b0;
            end else if (w_bubble) begin
                r_if_valid <= 1'b0;
            end
            // No instruction completes this cycle, so the delay slot is still ahead.
            if (w_redirect && !w_complete) begin
                r_pend_v   <= 1'b1;
                r_pend_npc <= i_redirect_npc;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (w_misalign && !i_stall) begin
                r_if_valid  <= 1'b1;
                r_if_instr  <= NOP;
                r_if_pc     <= r_pc;
                r_if_pc4    <= r_pc + 32'd4;
                r_fetch_exc <= 1'b1;
                r_pc        <= EXC_VECTOR;
                r_pend_v    <= 1'b0;
            end else if (!i_stall) begin
                r_fetch_exc <= 1'b0;
            end
`endif
        end
    end

    assign o_imem_req   = w_in_fetch;
    assign o_imem_addr  = w_in_fetch ? {r_pc[31:2], 2'b00} : 32'd0;
    assign o_fetch_busy = w_in_fetch && !i_imem_ack;
    assign o_if_valid   = r_if_valid;
    assign o_if_instr   = r_if_instr;
    assign o_if_pc      = r_if_pc;
    assign o_if_pc4     = r_if_pc4;
`ifdef FETCH_ALIGN_CHECK_EN
    assign o_fetch_exc  = r_fetch_exc;
`else
    assign o_fetch_exc  = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; memory returns 0xDEAD0000 ^ address for every fetch.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_npc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic        fetch_busy;
    logic        fetch_exc;

    int total = 0;
    int bad   = 0;

    fetch_sequencer dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_stall          (stall),
        .i_redirect_valid (redirect_valid),
        .i_redirect_npc   (redirect_npc),
        .o_imem_req       (imem_req),
        .o_imem_addr      (imem_addr),
        .i_imem_ack       (imem_ack),
        .i_imem_rdata     (imem_rdata),
        .o_if_valid       (if_valid),
        .o_if_instr       (if_instr),
        .o_if_pc          (if_pc),
        .o_if_pc4         (if_pc4),
        .o_fetch_busy     (fetch_busy),
        .o_fetch_exc      (fetch_exc)
    );

    assign imem_rdata = 32'hDEAD_0000 ^ imem_addr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_npc = 32'd0; imem_ack = 1'b1;
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_busy", {31'd0, fetch_busy}, 32'd0);
        chk("rst_exc", {31'd0, fetch_exc}, 32'd0);

        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        tick();                                  // IDLE -> FETCH
        chk("first_req", {31'd0, imem_req}, 32'd1);
        chk("first_addr", imem_addr, 32'h3000);
        chk("first_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("seq0_pc", if_pc, 32'h3000);
        chk("seq0_instr", if_instr, 32'hDEAD_3000);
        chk("seq0_pc4", if_pc4, 32'h3004);
        chk("seq0_valid", {31'd0, if_valid}, 32'd1);
        tick();
        chk("seq1_pc", if_pc, 32'h3004);

        // Redirect while 0x3008 completes: 0x3008 is the delay slot.
        redirect_valid = 1'b1; redirect_npc = 32'h3100;
        tick();
        redirect_valid = 1'b0;
        chk("dslot_pc", if_pc, 32'h3008);
        chk("dslot_addr", imem_addr, 32'h3100);
        tick();
        chk("tgt_pc", if_pc, 32'h3100);
        chk("tgt_instr", if_instr, 32'hDEAD_3100);

        // Stall coincident with the ack for 0x3104, held for three cycles.
        stall = 1'b1;
        tick();
        chk("hold_pc", if_pc, 32'h3100);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_addr", imem_addr, 32'd0);
        tick();
        tick();
        chk("hold3_pc", if_pc, 32'h3100);
        chk("hold3_valid", {31'd0, if_valid}, 32'd1);
        stall = 1'b0;
        tick();
        chk("skid_pc", if_pc, 32'h3104);
        chk("skid_instr", if_instr, 32'hDEAD_3104);
        chk("skid_next_addr", imem_addr, 32'h3108);
        tick();
        chk("post_skid_pc", if_pc, 32'h3108);

        // Ack withheld for two cycles with a redirect arriving during the wait.
        imem_ack = 1'b0;
        #1;
        chk("wait_busy", {31'd0, fetch_busy}, 32'd1);
        tick();
        chk("bubble_valid", {31'd0, if_valid}, 32'd0);
        chk("bubble_pc", if_pc, 32'h3108);
        redirect_valid = 1'b1; redirect_npc = 32'h3200;
        #1;
        chk("wait2_busy", {31'd0, fetch_busy}, 32'd1);
        tick();
        redirect_valid = 1'b0; imem_ack = 1'b1;
        chk("bubble2_valid", {31'd0, if_valid}, 32'd0);
        tick();
        chk("pend_dslot_pc", if_pc, 32'h310C);
        chk("pend_dslot_valid", {31'd0, if_valid}, 32'd1);
        chk("pend_addr", imem_addr, 32'h3200);
        chk("pend_busy", {31'd0, fetch_busy}, 32'd0);
        tick();
        chk("pend_tgt_pc", if_pc, 32'h3200);

        // PC wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_npc = 32'hFFFF_FFFC;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_dslot_pc", if_pc, 32'h3204);
        tick();
        chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", if_pc4, 32'h0000_0000);
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        tick();
        chk("wrap_next_pc", if_pc, 32'h0000_0000);

        // Reset during an outstanding request, then a late ack while IDLE.
        imem_ack = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'd0, if_valid}, 32'd0);
        chk("mid_rst_pc", if_pc, 32'd0);
        chk("mid_rst_instr", if_instr, 32'd0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0; imem_ack = 1'b1;
        tick();
        chk("late_ack_valid", {31'd0, if_valid}, 32'd0);
        chk("late_ack_addr", imem_addr, 32'h3000);
        tick();
        chk("restart_pc", if_pc, 32'h3000);
        chk("restart_exc", {31'd0, fetch_exc}, 32'd0);

`ifdef FETCH_ALIGN_CHECK_EN
        redirect_valid = 1'b1; redirect_npc = 32'h3102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_dslot_pc", if_pc, 32'h3004);
        chk("mis_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("exc_flag", {31'd0, fetch_exc}, 32'd1);
        chk("exc_instr", if_instr, 32'd0);
        chk("exc_pc", if_pc, 32'h3102);
        chk("exc_addr", imem_addr, 32'h4180);
        tick();
        chk("vec_pc", if_pc, 32'h4180);
        chk("vec_exc_clr", {31'd0, fetch_exc}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
